// File: rtl/seq_divider_pkg.sv
// Shared widths and FSM state encodings for the sequential divider.
package seq_divider_pkg;

  localparam int unsigned DW_DEF = 7;
  localparam int unsigned VW_DEF = 4;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OP   = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned VW = VW_DEF
) (
  input  logic [VW-1:0] r,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] r_next_c,
  output logic          q_bit_c
);

  logic [VW:0]   t;
  logic [VW-1:0] diff;

  // Trial subtraction; the result always fits VW bits when it is kept.
  always_comb begin
    t        = {r, bit_in};
    diff     = VW'(t - {1'b0, divisor});
    q_bit_c  = (t >= {1'b0, divisor});
    r_next_c = q_bit_c ? diff : t[VW-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock with start/ready/done handshake.
// Optional feature macro: DIVZERO_CHK_EN (early exit and div_by_zero flag on divisor 0).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] q;
  // The partial remainder's extra top bit never feeds a later step, so only VW bits are kept.
  logic [VW-1:0] r;
  logic [VW-1:0] dsr;
  logic [VW-1:0] r_next_c;
  logic          q_bit_c;
  logic          accept_c;
  logic          zero_c;
  logic          last_c;

  assign accept_c = (state == IDLE) && start;
  assign last_c   = (state == OP) && (cnt == '0);

`ifdef DIVZERO_CHK_EN
  assign zero_c = (divisor == '0);
`else
  assign zero_c = 1'b0;
`endif

  seq_divider_div_step #(.VW(VW)) u_div_step (
    .r        (r),
    .bit_in   (q[DW-1]),
    .divisor  (dsr),
    .r_next_c (r_next_c),
    .q_bit_c  (q_bit_c)
  );

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = zero_c ? DONE : OP;
      OP:      if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Iteration datapath: load operands on accept, one shift/subtract per OP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r   <= '0;
      q   <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (accept_c) begin
      r   <= '0;
      q   <= dividend;
      dsr <= divisor;
      cnt <= CW'(DW - 1);
    end else if (state == OP) begin
      r   <= r_next_c;
      q   <= {q[DW-2:0], q_bit_c};
      cnt <= cnt - 1'b1;
    end
  end

  // Handshake flags and result capture; results hold until the next completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready     <= 1'b1;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      ready <= (next_state == IDLE);
      done  <= (next_state == DONE);
      if (last_c) begin
        quotient  <= {q[DW-2:0], q_bit_c};
        remainder <= r_next_c;
      end else if (accept_c && zero_c) begin
        quotient  <= '1;
        remainder <= dividend[VW-1:0];
      end
    end
  end

`ifdef DIVZERO_CHK_EN
  // Flag follows the divisor of the most recent completed division.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     div_by_zero <= 1'b0;
    else if (accept_c && zero_c)    div_by_zero <= 1'b1;
    else if (last_c)                div_by_zero <= 1'b0;
  end
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
